// File: rtl/mtimer_multi.sv
// mtimer_multi: 64-bit machine timer with a programmable prescaler and N_CMP independent
// 64-bit compare channels, each driving a registered level interrupt.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset    synchronous, active-high reset
//   io_addr  word address within the timer window
//   io_we    write strobe (one cycle per write)
//   io_re    read strobe (one cycle per read)
//   io_din   write data
//   io_dout  registered read data, updated only on io_re
//   irq      per-channel level interrupt, registered
//   irq_any  OR of irq
//
// Word map: 0 MTIME_LO, 1 MTIME_HI, 2 CTRL, 3 STATUS, 4+2k CMP_LO[k], 5+2k CMP_HI[k].
module mtimer_multi #(
  parameter int unsigned N_CMP  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              io_we,
  input  logic              io_re,
  input  logic [31:0]       io_din,
  output logic [31:0]       io_dout,
  output logic [N_CMP-1:0]  irq,
  output logic              irq_any
);

  localparam logic [ADDR_W-1:0] AddrMtimeLo = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrMtimeHi = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrCtrl    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(3);

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q [N_CMP];
  logic [63:0]      cmp_d [N_CMP];
  logic             en_q;
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [N_CMP-1:0] irq_en_q;
  logic [31:0]      snap_q;

  logic [N_CMP-1:0] match;
  logic             tick;
  logic             wr_mlo, wr_mhi, wr_ctrl;
  logic [31:0]      ctrl_val;
  logic [31:0]      rdata;

  assign wr_mlo  = io_we && (io_addr == AddrMtimeLo);
  assign wr_mhi  = io_we && (io_addr == AddrMtimeHi);
  assign wr_ctrl = io_we && (io_addr == AddrCtrl);
  assign tick    = en_q && (pre_cnt_q == prescale_q);
  assign irq_any = |irq;

  always_comb begin
    for (int k = 0; k < N_CMP; k++) begin
      match[k] = (mtime_q >= cmp_q[k]);
    end
  end

  always_comb begin
    ctrl_val               = '0;
    ctrl_val[0]            = en_q;
    ctrl_val[8 +: PRE_W]   = prescale_q;
    ctrl_val[16 +: N_CMP]  = irq_en_q;
  end

  // Read mux; MTIME_HI returns the snapshot taken by the last MTIME_LO read.
  always_comb begin
    case (io_addr)
      AddrMtimeLo: rdata = mtime_q[31:0];
      AddrMtimeHi: rdata = snap_q;
      AddrCtrl:    rdata = ctrl_val;
      AddrStatus:  rdata = 32'(match);
      default:     rdata = '0;
    endcase
    for (int k = 0; k < N_CMP; k++) begin
      if (io_addr == ADDR_W'(4 + 2 * k)) rdata = cmp_q[k][31:0];
      if (io_addr == ADDR_W'(5 + 2 * k)) rdata = cmp_q[k][63:32];
    end
  end

  // A bus write to mtime wins over the tick of the same cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mlo) begin
      mtime_d[31:0] = io_din;
    end else if (wr_mhi) begin
      mtime_d[63:32] = io_din;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (wr_mlo || wr_mhi || wr_ctrl || tick) begin
      pre_cnt_d = '0;
    end else if (en_q) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < N_CMP; k++) begin
      cmp_d[k] = cmp_q[k];
      if (io_we && (io_addr == ADDR_W'(4 + 2 * k))) cmp_d[k][31:0]  = io_din;
      if (io_we && (io_addr == ADDR_W'(5 + 2 * k))) cmp_d[k][63:32] = io_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      en_q       <= 1'b1;
      prescale_q <= '0;
      irq_en_q   <= '1;
      pre_cnt_q  <= '0;
      snap_q     <= '0;
      io_dout    <= '0;
      irq        <= '0;
      for (int k = 0; k < N_CMP; k++) cmp_q[k] <= '1;
    end else begin
      mtime_q   <= mtime_d;
      pre_cnt_q <= pre_cnt_d;
      for (int k = 0; k < N_CMP; k++) cmp_q[k] <= cmp_d[k];
      if (wr_ctrl) begin
        en_q       <= io_din[0];
        prescale_q <= io_din[8 +: PRE_W];
        irq_en_q   <= io_din[16 +: N_CMP];
      end
      // Enable applies at the register, STATUS still shows the raw match.
      irq <= match & irq_en_q;
      if (io_re) begin
        io_dout <= rdata;
        if (io_addr == AddrMtimeLo) snap_q <= mtime_q[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mtimer_multi.sv
// tb_mtimer_multi: directed and randomized bench for mtimer_multi with a cycle-level
// reference model built from the register-map rules.
module tb_mtimer_multi;

  logic        clk;
  logic        reset;
  logic [4:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_din;
  logic [31:0] io_dout;
  logic [1:0]  irq;
  logic        irq_any;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [2];
  bit          m_en;
  int          m_pre;
  int          m_cnt;
  logic [1:0]  m_irq_en;
  logic [31:0] m_snap;
  logic [31:0] m_dout;
  logic [1:0]  m_irq;

  logic [31:0] r1, r2;

  mtimer_multi #(.N_CMP(2), .ADDR_W(5), .PRE_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_addr (io_addr),
    .io_we   (io_we),
    .io_re   (io_re),
    .io_din  (io_din),
    .io_dout (io_dout),
    .irq     (irq),
    .irq_any (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp[0] = {64{1'b1}};
    m_cmp[1] = {64{1'b1}};
    m_en     = 1'b1;
    m_pre    = 0;
    m_cnt    = 0;
    m_irq_en = 2'b11;
    m_snap   = 32'd0;
    m_dout   = 32'd0;
    m_irq    = 2'b00;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    logic [31:0] v;
    v = 32'd0;
    case (addr)
      5'd0: v = m_mtime[31:0];
      5'd1: v = m_snap;
      5'd2: v = {14'd0, m_irq_en, m_pre[7:0], 7'd0, m_en};
      5'd3: v = {30'd0, m_mtime >= m_cmp[1], m_mtime >= m_cmp[0]};
      5'd4: v = m_cmp[0][31:0];
      5'd5: v = m_cmp[0][63:32];
      5'd6: v = m_cmp[1][31:0];
      5'd7: v = m_cmp[1][63:32];
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the state visible before the edge.
  task automatic model_step(input bit we, input bit re, input logic [4:0] addr,
                            input logic [31:0] din);
    logic [63:0] old;
    logic [1:0]  nirq;
    bit          tick, mt_wr, ctrl_wr;
    old   = m_mtime;
    tick  = m_en && (m_cnt == m_pre);
    for (int k = 0; k < 2; k++) nirq[k] = (old >= m_cmp[k]) && m_irq_en[k];
    if (re) begin
      m_dout = model_read(addr);
      if (addr == 5'd0) m_snap = old[63:32];
    end
    mt_wr   = we && (addr == 5'd0 || addr == 5'd1);
    ctrl_wr = we && (addr == 5'd2);
    if (we) begin
      case (addr)
        5'd0: m_mtime[31:0]  = din;
        5'd1: m_mtime[63:32] = din;
        5'd2: begin
          m_en     = din[0];
          m_pre    = int'(din[15:8]);
          m_irq_en = din[17:16];
        end
        5'd4: m_cmp[0][31:0]  = din;
        5'd5: m_cmp[0][63:32] = din;
        5'd6: m_cmp[1][31:0]  = din;
        5'd7: m_cmp[1][63:32] = din;
        default: ;
      endcase
    end
    if (!mt_wr && tick) m_mtime = old + 64'd1;
    if (mt_wr || ctrl_wr || tick) m_cnt = 0;
    else if (m_en) m_cnt = m_cnt + 1;
    m_irq = nirq;
  endtask

  task automatic cyc(input bit we, input bit re, input logic [4:0] addr,
                     input logic [31:0] din);
    io_we   = we;
    io_re   = re;
    io_addr = addr;
    io_din  = din;
    model_step(we, re, addr, din);
    @(posedge clk);
    #1;
    io_we = 1'b0;
    io_re = 1'b0;
    check("irq", irq, m_irq);
    check("irq_any", irq_any, |m_irq);
    check("dout", io_dout, m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_irq", irq, 2'b00);
    check("rst_dout", io_dout, 32'd0);
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    bit          rwe, rre;
    reset   = 1'b1;
    io_addr = 5'd0;
    io_we   = 1'b0;
    io_re   = 1'b0;
    io_din  = 32'd0;
    do_reset();

    // Free-running at PRESCALE=0.
    idle(10);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    check("idle_window", (io_dout == 32'd9) || (io_dout == 32'd10), 1'b1);
    check("idle_irq", irq, 2'b00);

    // PRESCALE=3: 40 cycles between reads -> +10.
    cyc(1'b1, 1'b0, 5'd2, 32'h0000_0301);
    idle(3);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    r1 = io_dout;
    idle(39);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    r2 = io_dout;
    check("prescale_delta", r2 - r1, 32'd10);

    // Compare channel 0 at 20.
    cyc(1'b1, 1'b0, 5'd2, 32'h0003_0001);
    cyc(1'b1, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd1, 32'd0);
    cyc(1'b1, 1'b0, 5'd5, 32'd0);
    cyc(1'b1, 1'b0, 5'd4, 32'd20);
    idle(25);
    check("cmp_irq0_high", irq[0], 1'b1);
    check("cmp_irq1_low", irq[1], 1'b0);
    cyc(1'b1, 1'b0, 5'd4, 32'd1000);
    cyc(1'b0, 1'b0, 5'd0, 32'd0);
    check("cmp_irq0_fall", irq[0], 1'b0);

    // Carry from LO into HI with coherent LO/HI reads straddling it.
    cyc(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, 5'd1, 32'd5);
    idle(1);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    check("coh_lo", io_dout, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 5'd1, 32'd0);
    check("coh_hi", io_dout, 32'd5);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    check("wrap_lo", io_dout, 32'd1);
    cyc(1'b0, 1'b1, 5'd1, 32'd0);
    check("wrap_hi", io_dout, 32'd6);

    // Write on a tick cycle: written value, no increment.
    cyc(1'b1, 1'b0, 5'd0, 32'h0000_1234);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    check("write_beats_tick", io_dout, 32'h0000_1234);

    // Matching channel 0 with its interrupt enable cleared.
    cyc(1'b1, 1'b0, 5'd5, 32'd0);
    cyc(1'b1, 1'b0, 5'd4, 32'd0);
    idle(1);
    check("en_irq_before", irq[0], 1'b1);
    cyc(1'b1, 1'b0, 5'd2, 32'h0002_0001);
    idle(1);
    check("en_irq_masked", irq[0], 1'b0);
    cyc(1'b0, 1'b1, 5'd3, 32'd0);
    check("en_status_raw", io_dout[0], 1'b1);

    // Randomized traffic over the map plus unmapped addresses.
    for (int i = 0; i < 600; i++) begin
      ra  = 5'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) ra = 5'd31;
      rwe = ($urandom_range(0, 3) == 0);
      rre = ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      case (ra)
        5'd0:       rd = 32'($urandom_range(0, 100));
        5'd1:       rd = 32'($urandom_range(0, 1));
        5'd2:       rd = {14'd0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 7'd0,
                          1'($urandom_range(0, 7) != 0)};
        5'd4, 5'd6: rd = 32'($urandom_range(0, 200));
        5'd5, 5'd7: rd = 32'($urandom_range(0, 1));
        default: ;
      endcase
      cyc(rwe, rre, ra, rd);
    end

    // Reset in the middle of counting.
    cyc(1'b1, 1'b0, 5'd2, 32'h0003_0001);
    cyc(1'b1, 1'b0, 5'd5, 32'd0);
    cyc(1'b1, 1'b0, 5'd4, 32'd0);
    idle(5);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    do_reset();
    cyc(1'b0, 1'b1, 5'd4, 32'd0);
    check("rst_cmp_lo", io_dout, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 5'd5, 32'd0);
    check("rst_cmp_hi", io_dout, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 5'd0, 32'd0);
    check("rst_mtime", io_dout, 32'd2);
    check("rst_irq_after", irq, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
